// File: rtl/alu_seq_if.sv
// Request/result handshake bundle between execute control and the ALU sequencer.
// master = requester/consumer side, slave = alu_seq.
interface alu_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        req_carry;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_n;
  logic        res_z;
  logic        res_c;
  logic        res_v;
  logic        busy;

  modport master (
    output req_valid, req_op, req_a, req_b, req_carry, res_ready,
    input  req_ready, res_valid, res_data, res_n, res_z, res_c, res_v, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_carry, res_ready,
    output req_ready, res_valid, res_data, res_n, res_z, res_c, res_v, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Sequences one request through the external 8-bit ALU (two passes for ADD16) and derives N/Z/C/V.
// Result valid 2 cycles after accept (3 for ADD16); result held until res_ready, no request queueing.
module alu_seq (
  input  logic       clk,
  input  logic       reset,
  alu_seq_if.slave   bus,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [4:0] alu_mode,
  output logic       alu_carry_in,
  input  logic [7:0] alu_out
);

  typedef enum logic [1:0] {IDLE, EXEC_LO, EXEC_HI, DONE} state_t;

  state_t      state;
  logic [2:0]  op;
  logic [7:0]  a_hi;
  logic [7:0]  b_hi;
  logic        carry;
  logic [15:0] res_data;
  logic        res_n;
  logic        res_z;
  logic        res_c;
  logic        res_v;
  logic        pass_c;
  logic        pass_v;

  function automatic logic [4:0] mode_of(input logic [2:0] o);
    if (o <= 3'd4) return {2'b00, o};
    else if (o == 3'd5) return 5'd0;
    else return 5'd5;
  endfunction

  // Carry/overflow of the add pass currently on the ALU, rebuilt from its operands and result.
  assign pass_c = (alu_out < alu_a) || (alu_carry_in && (alu_out == alu_a));
  assign pass_v = (alu_a[7] == alu_b[7]) && (alu_out[7] != alu_a[7]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      op           <= 3'd0;
      a_hi         <= 8'd0;
      b_hi         <= 8'd0;
      carry        <= 1'b0;
      alu_a        <= 8'd0;
      alu_b        <= 8'd0;
      alu_mode     <= 5'd0;
      alu_carry_in <= 1'b0;
      res_data     <= 16'd0;
      res_n        <= 1'b0;
      res_z        <= 1'b0;
      res_c        <= 1'b0;
      res_v        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            op           <= bus.req_op;
            a_hi         <= bus.req_a[15:8];
            b_hi         <= bus.req_b[15:8];
            carry        <= bus.req_carry;
            alu_a        <= bus.req_a[7:0];
            alu_b        <= bus.req_b[7:0];
            alu_mode     <= mode_of(bus.req_op);
            alu_carry_in <= bus.req_carry;
            state        <= EXEC_LO;
          end
        end
        EXEC_LO: begin
          res_data <= {8'd0, alu_out};
          if (op == 3'd5) begin
            alu_a        <= a_hi;
            alu_b        <= b_hi;
            alu_carry_in <= pass_c;
            state        <= EXEC_HI;
          end else begin
            res_n <= alu_out[7];
            res_z <= (alu_out == 8'd0);
            case (op)
              3'd0: begin
                res_c <= pass_c;
                res_v <= pass_v;
              end
              3'd4: begin
                res_c <= alu_a[7];
                res_v <= 1'b0;
              end
              default: begin
                res_c <= carry;
                res_v <= 1'b0;
              end
            endcase
            alu_a        <= 8'd0;
            alu_b        <= 8'd0;
            alu_mode     <= 5'd0;
            alu_carry_in <= 1'b0;
            state        <= DONE;
          end
        end
        EXEC_HI: begin
          res_data[15:8] <= alu_out;
          res_n          <= alu_out[7];
          res_z          <= (alu_out == 8'd0) && (res_data[7:0] == 8'd0);
          res_c          <= pass_c;
          res_v          <= pass_v;
          alu_a          <= 8'd0;
          alu_b          <= 8'd0;
          alu_mode       <= 5'd0;
          alu_carry_in   <= 1'b0;
          state          <= DONE;
        end
        DONE: begin
          if (bus.res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.res_valid = (state == DONE);
  assign bus.res_data  = res_data;
  assign bus.res_n     = res_n;
  assign bus.res_z     = res_z;
  assign bus.res_c     = res_c;
  assign bus.res_v     = res_v;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: behavioural ALU plus an arithmetic reference model of results and flags.
module tb_alu_seq;
  logic       clk;
  logic       reset;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [4:0] alu_mode;
  logic       alu_carry_in;
  logic [7:0] alu_out;

  int checks = 0;
  int errors = 0;

  alu_seq_if bus ();

  alu_seq dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_mode     (alu_mode),
    .alu_carry_in (alu_carry_in),
    .alu_out      (alu_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (alu_mode)
      5'd0:    alu_out = alu_a + alu_b + {7'd0, alu_carry_in};
      5'd1:    alu_out = alu_a & alu_b;
      5'd2:    alu_out = alu_a | alu_b;
      5'd3:    alu_out = alu_a ^ alu_b;
      5'd4:    alu_out = {alu_a[6:0], 1'b0};
      default: alu_out = alu_a;
    endcase
  end

  // Expected {data, n, z, c, v} from true integer arithmetic.
  function automatic logic [19:0] model(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic cin);
    int us, sa, sb, sum;
    logic [15:0] d;
    logic n, z, c, v;
    d = 16'd0;
    c = cin;
    v = 1'b0;
    case (op)
      3'd0: begin
        us  = int'(a[7:0]) + int'(b[7:0]) + int'(cin);
        d   = {8'd0, us[7:0]};
        c   = (us > 255);
        sa  = a[7] ? int'(a[7:0]) - 256 : int'(a[7:0]);
        sb  = b[7] ? int'(b[7:0]) - 256 : int'(b[7:0]);
        sum = sa + sb + int'(cin);
        v   = (sum > 127) || (sum < -128);
      end
      3'd1: d = {8'd0, a[7:0] & b[7:0]};
      3'd2: d = {8'd0, a[7:0] | b[7:0]};
      3'd3: d = {8'd0, a[7:0] ^ b[7:0]};
      3'd4: begin
        us = (int'(a[7:0]) * 2) % 256;
        d  = {8'd0, us[7:0]};
        c  = (a[7:0] >= 8'd128);
      end
      3'd5: begin
        us  = int'(a) + int'(b) + int'(cin);
        d   = us[15:0];
        c   = (us > 65535);
        sa  = a[15] ? int'(a) - 65536 : int'(a);
        sb  = b[15] ? int'(b) - 65536 : int'(b);
        sum = sa + sb + int'(cin);
        v   = (sum > 32767) || (sum < -32768);
      end
      default: d = {8'd0, a[7:0]};
    endcase
    n = (op == 3'd5) ? d[15] : d[7];
    z = (d == 16'd0);
    return {d, n, z, c, v};
  endfunction

  function automatic logic [19:0] observed();
    return {bus.res_data, bus.res_n, bus.res_z, bus.res_c, bus.res_v};
  endfunction

  function automatic logic [4:0] exp_mode(input logic [2:0] op);
    if (op < 3'd5) return {2'b00, op};
    if (op == 3'd5) return 5'd0;
    return 5'd5;
  endfunction

  // Waits for req_ready, presents a request, returns #1 after the accept edge.
  task automatic send_req(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic cin);
    int n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.req_ready) begin
      errors++;
      $display("FAIL req_ready_timeout got %0b want 1", bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_carry = cin;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // Cycles from the accept cycle until res_valid is seen (capped at 10).
  task automatic wait_res(output int lat);
    lat = 1;
    while (!bus.res_valid && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic consume();
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.req_ready, bus.busy, bus.res_valid} !== 3'b100) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 100", {bus.req_ready, bus.busy, bus.res_valid});
    end
    checks++;
    if ({alu_a, alu_b, alu_mode, alu_carry_in, observed()} !== 42'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", {alu_a, alu_b, alu_mode, alu_carry_in, observed()});
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b want 1", bus.req_ready);
    end
  endtask

  task automatic test_directed();
    logic [2:0]  t_op [6] = '{3'd0, 3'd5, 3'd5, 3'd4, 3'd3, 3'd6};
    logic [15:0] t_a  [6] = '{16'h0050, 16'h00FF, 16'hFFFF, 16'h0081, 16'h005A, 16'h0080};
    logic [15:0] t_b  [6] = '{16'h0050, 16'h0001, 16'h0001, 16'h0000, 16'h005A, 16'h0000};
    logic        t_c  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [19:0] e;
    int lat;
    for (int i = 0; i < 6; i++) begin
      e = model(t_op[i], t_a[i], t_b[i], t_c[i]);
      send_req(t_op[i], t_a[i], t_b[i], t_c[i]);
      checks++;
      if ({alu_mode, alu_a} !== {exp_mode(t_op[i]), t_a[i][7:0]}) begin
        errors++;
        $display("FAIL dir_alu_drive[%0d] got %h want %h", i, {alu_mode, alu_a},
                 {exp_mode(t_op[i]), t_a[i][7:0]});
      end
      wait_res(lat);
      checks++;
      if (lat !== ((t_op[i] == 3'd5) ? 3 : 2)) begin
        errors++;
        $display("FAIL dir_latency[%0d] got %0d want %0d", i, lat, (t_op[i] == 3'd5) ? 3 : 2);
      end
      checks++;
      if (observed() !== e) begin
        errors++;
        $display("FAIL dir_result[%0d] got %h want %h", i, observed(), e);
      end
      consume();
    end
    checks++;
    if (model(3'd0, 16'h0050, 16'h0050, 1'b0) !== {16'h00A0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL model_add_overflow got %h want %h", model(3'd0, 16'h0050, 16'h0050, 1'b0),
               {16'h00A0, 4'b1001});
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [15:0] a, b;
    logic        cin;
    logic [19:0] e;
    int lat;
    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom);
      e   = model(op, a, b, cin);
      send_req(op, a, b, cin);
      wait_res(lat);
      checks++;
      if (lat !== ((op == 3'd5) ? 3 : 2)) begin
        errors++;
        $display("FAIL rnd_latency[%0d] op %0d got %0d", i, op, lat);
      end
      checks++;
      if (observed() !== e) begin
        errors++;
        $display("FAIL rnd_result[%0d] op %0d a %h b %h c %b got %h want %h",
                 i, op, a, b, cin, observed(), e);
      end
      consume();
      checks++;
      if (bus.req_ready !== 1'b1) begin
        errors++;
        $display("FAIL rnd_ready_after[%0d] got %b want 1", i, bus.req_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [19:0] e1, e2;
    int lat;
    e1 = model(3'd0, 16'h00C3, 16'h0071, 1'b1);
    e2 = model(3'd2, 16'h0011, 16'h0024, 1'b0);
    send_req(3'd0, 16'h00C3, 16'h0071, 1'b1);
    wait_res(lat);
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd2;
    bus.req_a     = 16'h0011;
    bus.req_b     = 16'h0024;
    bus.req_carry = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.req_ready, bus.res_valid, observed()} !== {2'b01, e1}) begin
        errors++;
        $display("FAIL bp_hold[%0d] got %h want %h", i, {bus.req_ready, bus.res_valid, observed()},
                 {2'b01, e1});
      end
      @(posedge clk); #1;
    end
    consume();
    checks++;
    if ({bus.req_ready, bus.res_valid} !== 2'b10) begin
      errors++;
      $display("FAIL bp_after_consume got %b want 10", {bus.req_ready, bus.res_valid});
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_second_accept got %b want 1", bus.busy);
    end
    wait_res(lat);
    checks++;
    if (observed() !== e2 || lat !== 2) begin
      errors++;
      $display("FAIL bp_second_result got %h lat %0d want %h lat 2", observed(), lat, e2);
    end
    consume();
  endtask

  task automatic test_reset_mid();
    int lat;
    send_req(3'd5, 16'h1234, 16'h4321, 1'b0);
    @(posedge clk); #1;
    checks++;
    if ({bus.busy, alu_a, alu_b} !== {1'b1, 8'h12, 8'h43}) begin
      errors++;
      $display("FAIL mid_exec_hi got %h want %h", {bus.busy, alu_a, alu_b}, {1'b1, 8'h12, 8'h43});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.req_ready, bus.busy, bus.res_valid, alu_a, alu_b, alu_mode, alu_carry_in, observed()}
        !== {3'b100, 42'd0}) begin
      errors++;
      $display("FAIL mid_reset_clear got %h want %h",
               {bus.req_ready, bus.busy, bus.res_valid, alu_a, alu_b, alu_mode, alu_carry_in, observed()},
               {3'b100, 42'd0});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    send_req(3'd0, 16'h0001, 16'h0001, 1'b0);
    wait_res(lat);
    checks++;
    if ({observed(), lat[3:0]} !== {16'h0002, 4'b0000, 4'd2}) begin
      errors++;
      $display("FAIL mid_after_reset got %h lat %0d want 0002 flags 0 lat 2", observed(), lat);
    end
    consume();
  endtask

  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_a     = 16'd0;
    bus.req_b     = 16'd0;
    bus.req_carry = 1'b0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
